// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and branch/cmov
// condition evaluation, feeding the M pipeline register of the memory stage.
module execute_stage #(
  parameter int          WORD     = 64,
  parameter logic [2:0]  STAT_AOK = 3'd1,
  parameter logic [3:0]  RNONE    = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      d_icode,
  input  logic [3:0]      d_ifun,
  input  logic [WORD-1:0] d_valC,
  input  logic [WORD-1:0] d_valA,
  input  logic [WORD-1:0] d_valB,
  input  logic [3:0]      d_dstE,
  input  logic [3:0]      d_dstM,
  input  logic [2:0]      d_stat,
  input  logic            e_stall,
  input  logic            e_bubble,
  input  logic            m_bubble,
  input  logic            set_cc_block,
  output logic [WORD-1:0] e_valE,
  output logic [3:0]      e_dstE,
  output logic            e_cnd,
  output logic [3:0]      M_icode,
  output logic            M_cnd,
  output logic [WORD-1:0] M_valE,
  output logic [WORD-1:0] M_valA,
  output logic [3:0]      M_dstE,
  output logic [3:0]      M_dstM,
  output logic [2:0]      M_stat,
  output logic [2:0]      cc
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [WORD-1:0] MINUS8 = {{(WORD-4){1'b1}}, 4'b1000};
  localparam logic [WORD-1:0] PLUS8  = {{(WORD-4){1'b0}}, 4'b1000};

  logic [3:0]      e_icode_r, e_ifun_r, e_dste_r, e_dstm_r;
  logic [WORD-1:0] e_valc_r, e_vala_r, e_valb_r;
  logic [2:0]      e_stat_r;

  logic [3:0]      m_icode_r, m_dste_r, m_dstm_r;
  logic            m_cnd_r;
  logic [WORD-1:0] m_vale_r, m_vala_r;
  logic [2:0]      m_stat_r;
  logic [2:0]      cc_r;

  logic [WORD-1:0] alua_s, alub_s, alut_s;
  logic [3:0]      alufun_s;
  logic            zf_s, sf_s, of_s, cnd_s, cc_we_s;
  logic [3:0]      dste_s;

  // E pipeline register: reset, then bubble over stall, then load from decode
  always_ff @(posedge clk) begin
    if (rst || e_bubble) begin
      e_icode_r <= I_NOP;
      e_ifun_r  <= 4'h0;
      e_valc_r  <= '0;
      e_vala_r  <= '0;
      e_valb_r  <= '0;
      e_dste_r  <= RNONE;
      e_dstm_r  <= RNONE;
      e_stat_r  <= STAT_AOK;
    end else if (e_stall) begin
      e_icode_r <= e_icode_r;
      e_ifun_r  <= e_ifun_r;
      e_valc_r  <= e_valc_r;
      e_vala_r  <= e_vala_r;
      e_valb_r  <= e_valb_r;
      e_dste_r  <= e_dste_r;
      e_dstm_r  <= e_dstm_r;
      e_stat_r  <= e_stat_r;
    end else begin
      e_icode_r <= d_icode;
      e_ifun_r  <= d_ifun;
      e_valc_r  <= d_valC;
      e_vala_r  <= d_valA;
      e_valb_r  <= d_valB;
      e_dste_r  <= d_dstE;
      e_dstm_r  <= d_dstM;
      e_stat_r  <= d_stat;
    end
  end

  // ALU operand and function selection by instruction class
  always_comb begin
    alua_s   = '0;
    alub_s   = '0;
    alufun_s = ALU_ADD;
    case (e_icode_r)
      I_RRMOVQ:           alua_s = e_vala_r;
      I_IRMOVQ:           alua_s = e_valc_r;
      I_RMMOVQ, I_MRMOVQ: begin alua_s = e_valc_r; alub_s = e_valb_r; end
      I_OPQ:              begin alua_s = e_vala_r; alub_s = e_valb_r; alufun_s = e_ifun_r; end
      I_CALL, I_PUSHQ:    begin alua_s = MINUS8;   alub_s = e_valb_r; end
      I_RET, I_POPQ:      begin alua_s = PLUS8;    alub_s = e_valb_r; end
      default:            begin alua_s = '0;       alub_s = '0; end
    endcase
  end

  // ALU datapath and flag generation
  always_comb begin
    alut_s = '0;
    of_s   = 1'b0;
    case (alufun_s)
      ALU_SUB: begin
        alut_s = alub_s - alua_s;
        of_s   = (alua_s[WORD-1] != alub_s[WORD-1]) && (alut_s[WORD-1] != alub_s[WORD-1]);
      end
      ALU_AND: alut_s = alub_s & alua_s;
      ALU_XOR: alut_s = alub_s ^ alua_s;
      default: begin
        alut_s = alub_s + alua_s;
        of_s   = (alua_s[WORD-1] == alub_s[WORD-1]) && (alut_s[WORD-1] != alua_s[WORD-1]);
      end
    endcase
    zf_s = (alut_s == '0);
    sf_s = alut_s[WORD-1];
  end

  // Branch/cmov condition from the architectural CC; cc_r is {ZF,SF,OF}
  always_comb begin
    cnd_s = 1'b0;
    if (e_icode_r == I_RRMOVQ || e_icode_r == I_JXX) begin
      case (e_ifun_r)
        4'h0:    cnd_s = 1'b1;
        4'h1:    cnd_s = (cc_r[1] ^ cc_r[0]) | cc_r[2];
        4'h2:    cnd_s = cc_r[1] ^ cc_r[0];
        4'h3:    cnd_s = cc_r[2];
        4'h4:    cnd_s = ~cc_r[2];
        4'h5:    cnd_s = ~(cc_r[1] ^ cc_r[0]);
        4'h6:    cnd_s = ~(cc_r[1] ^ cc_r[0]) & ~cc_r[2];
        default: cnd_s = 1'b0;
      endcase
    end else begin
      cnd_s = 1'b0;
    end
  end

  // A cmov that fails its condition writes no register
  always_comb begin
    if (e_icode_r == I_RRMOVQ && !cnd_s) begin
      dste_s = RNONE;
    end else begin
      dste_s = e_dste_r;
    end
  end

  // A stalled OPq is only committed once, because the hazard unit bubbles M while E holds
  assign cc_we_s = (e_icode_r == I_OPQ) && (e_stat_r == STAT_AOK) && !set_cc_block && !m_bubble;

  // Condition-code register
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r <= 3'b100;
    end else if (cc_we_s) begin
      cc_r <= {zf_s, sf_s, of_s};
    end else begin
      cc_r <= cc_r;
    end
  end

  // M pipeline register: never stalled
  always_ff @(posedge clk) begin
    if (rst || m_bubble) begin
      m_icode_r <= I_NOP;
      m_cnd_r   <= 1'b0;
      m_vale_r  <= '0;
      m_vala_r  <= '0;
      m_dste_r  <= RNONE;
      m_dstm_r  <= RNONE;
      m_stat_r  <= STAT_AOK;
    end else begin
      m_icode_r <= e_icode_r;
      m_cnd_r   <= cnd_s;
      m_vale_r  <= alut_s;
      m_vala_r  <= e_vala_r;
      m_dste_r  <= dste_s;
      m_dstm_r  <= e_dstm_r;
      m_stat_r  <= e_stat_r;
    end
  end

  assign e_valE  = alut_s;
  assign e_dstE  = dste_s;
  assign e_cnd   = cnd_s;
  assign M_icode = m_icode_r;
  assign M_cnd   = m_cnd_r;
  assign M_valE  = m_vale_r;
  assign M_valA  = m_vala_r;
  assign M_dstE  = m_dste_r;
  assign M_dstM  = m_dstm_r;
  assign M_stat  = m_stat_r;
  assign cc      = cc_r;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [2:0]  d_stat;
  logic        e_stall, e_bubble, m_bubble, set_cc_block;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_cnd, M_cnd;
  logic [2:0]  M_stat, cc;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_stat(d_stat),
    .e_stall(e_stall), .e_bubble(e_bubble), .m_bubble(m_bubble), .set_cc_block(set_cc_block),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                      input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
    d_icode = ic; d_ifun = fn; d_valC = vc; d_valA = va; d_valB = vb;
    d_dstE = de; d_dstM = 4'hF; d_stat = 3'd1;
  endtask

  task automatic drive_nop();
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
  endtask

  task automatic test_reset();
    e_stall = 1'b0; e_bubble = 1'b0; m_bubble = 1'b0; set_cc_block = 1'b0;
    load(4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 4'h2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got=%h exp=1", M_icode); end
    checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL reset_dst got=%h/%h exp=F/F", M_dstE, M_dstM); end
    checks++; if (M_stat !== 3'd1) begin errors++; $display("FAIL reset_stat got=%0d exp=1", M_stat); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc got=%b exp=100", cc); end
    checks++; if (M_valE !== 64'd0 || M_cnd !== 1'b0) begin errors++; $display("FAIL reset_vale got=%h cnd=%b exp=0", M_valE, M_cnd); end
    checks++; if (e_valE !== 64'd0 || e_dstE !== 4'hF) begin errors++; $display("FAIL reset_e got=%h/%h exp=0/F", e_valE, e_dstE); end
  endtask

  task automatic test_opq_sub();
    load(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h2);
    step();
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_e_valE got=%h exp=FFFFFFFFFFFFFFFE", e_valE); end
    drive_nop();
    step();
    checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_M_valE got=%h exp=FFFFFFFFFFFFFFFE", M_valE); end
    checks++; if (M_icode !== 4'h6 || M_dstE !== 4'h2) begin errors++; $display("FAIL sub_M_ctl got=%h/%h exp=6/2", M_icode, M_dstE); end
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL sub_cc got=%b exp=010", cc); end
  endtask

  task automatic test_overflow_cc();
    load(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4);
    step();
    drive_nop();
    step();
    checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL ovf_M_valE got=%h exp=FFFFFFFFFFFFFFFE", M_valE); end
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL ovf_cc got=%b exp=011", cc); end
    // sub 5-5 would set ZF; blocked here
    load(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2);
    step();
    drive_nop();
    set_cc_block = 1'b1;
    step();
    set_cc_block = 1'b0;
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL ccblock_cc got=%b exp=011", cc); end
    checks++; if (M_valE !== 64'd0) begin errors++; $display("FAIL ccblock_M_valE got=%h exp=0", M_valE); end
    // a non-AOK OPq must not write CC either
    load(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2);
    d_stat = 3'd2;
    step();
    drive_nop();
    step();
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL stat_cc got=%b exp=011", cc); end
    checks++; if (M_stat !== 3'd2) begin errors++; $display("FAIL stat_M_stat got=%0d exp=2", M_stat); end
  endtask

  task automatic test_cmov_jxx();
    load(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h4);
    step();
    load(4'h2, 4'h1, 64'd0, 64'd9, 64'd0, 4'h3);
    step();
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL add_cc got=%b exp=000", cc); end
    checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'hF) begin errors++; $display("FAIL cmovle_false_e got=%b/%h exp=0/F", e_cnd, e_dstE); end
    load(4'h6, 4'h3, 64'd0, 64'd5, 64'd5, 4'h4);
    step();
    checks++; if (M_dstE !== 4'hF || M_valE !== 64'd9 || M_cnd !== 1'b0) begin errors++; $display("FAIL cmovle_false_M got=%h/%h/%b exp=F/9/0", M_dstE, M_valE, M_cnd); end
    // xor result zero now in E; next cmov sees ZF=1 back to back
    load(4'h2, 4'h1, 64'd0, 64'd9, 64'd0, 4'h3);
    step();
    checks++; if (M_valE !== 64'd0 || M_dstE !== 4'h4) begin errors++; $display("FAIL xor_M got=%h/%h exp=0/4", M_valE, M_dstE); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL xor_cc got=%b exp=100", cc); end
    checks++; if (e_cnd !== 1'b1 || e_dstE !== 4'h3) begin errors++; $display("FAIL cmovle_true_e got=%b/%h exp=1/3", e_cnd, e_dstE); end
    load(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF);
    step();
    checks++; if (M_dstE !== 4'h3 || M_valE !== 64'd9 || M_cnd !== 1'b1) begin errors++; $display("FAIL cmovle_true_M got=%h/%h/%b exp=3/9/1", M_dstE, M_valE, M_cnd); end
    checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL je_cnd got=%b exp=1", e_cnd); end
    load(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF);
    step();
    checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL jne_cnd got=%b exp=0", e_cnd); end
    load(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF);
    step();
    checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL jbadfun_cnd got=%b exp=0", e_cnd); end
    load(4'h3, 4'h0, 64'h1234, 64'd0, 64'd0, 4'h5);
    step();
    checks++; if (e_cnd !== 1'b0 || e_valE !== 64'h1234 || e_dstE !== 4'h5) begin errors++; $display("FAIL irmovq_e got=%b/%h/%h exp=0/1234/5", e_cnd, e_valE, e_dstE); end
    drive_nop();
    step();
  endtask

  task automatic test_stack_mem();
    load(4'hA, 4'h0, 64'd0, 64'h55, 64'h100, 4'h4);
    step();
    load(4'hB, 4'h0, 64'd0, 64'h0, 64'hF8, 4'h4);
    step();
    checks++; if (M_valE !== 64'hF8 || M_valA !== 64'h55 || M_icode !== 4'hA) begin errors++; $display("FAIL pushq got=%h/%h/%h exp=F8/55/A", M_valE, M_valA, M_icode); end
    load(4'h8, 4'h0, 64'h40, 64'h2A, 64'h100, 4'h4);
    step();
    checks++; if (M_valE !== 64'h100) begin errors++; $display("FAIL popq got=%h exp=100", M_valE); end
    load(4'h5, 4'h0, 64'h10, 64'd0, 64'h20, 4'hF);
    step();
    checks++; if (M_valA !== 64'h2A || M_valE !== 64'hF8) begin errors++; $display("FAIL call got=%h/%h exp=2A/F8", M_valA, M_valE); end
    drive_nop();
    step();
    checks++; if (M_valE !== 64'h30 || M_icode !== 4'h5) begin errors++; $display("FAIL mrmovq got=%h/%h exp=30/5", M_valE, M_icode); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL stack_cc got=%b exp=100", cc); end
  endtask

  task automatic test_stall_bubble();
    load(4'h6, 4'h2, 64'd0, 64'hF0, 64'h3C, 4'h6);
    step();
    load(4'h3, 4'h0, 64'h77, 64'd0, 64'd0, 4'h7);
    e_stall = 1'b1; m_bubble = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (e_valE !== 64'h30 || M_icode !== 4'h1 || cc !== 3'b100) begin errors++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=30/1/100", i, e_valE, M_icode, cc); end
    end
    e_stall = 1'b0; m_bubble = 1'b0;
    step();
    checks++; if (M_icode !== 4'h6 || M_valE !== 64'h30 || cc !== 3'b000) begin errors++; $display("FAIL stall_release got=%h/%h/%b exp=6/30/000", M_icode, M_valE, cc); end
    checks++; if (e_valE !== 64'h77) begin errors++; $display("FAIL stall_next_e got=%h exp=77", e_valE); end
    load(4'h6, 4'h3, 64'd0, 64'd1, 64'd2, 4'h2);
    e_stall = 1'b1; e_bubble = 1'b1;
    step();
    e_stall = 1'b0; e_bubble = 1'b0;
    checks++; if (e_valE !== 64'd0 || e_dstE !== 4'hF) begin errors++; $display("FAIL ebubble_e got=%h/%h exp=0/F", e_valE, e_dstE); end
    checks++; if (M_valE !== 64'h77 || M_dstE !== 4'h7) begin errors++; $display("FAIL ebubble_M got=%h/%h exp=77/7", M_valE, M_dstE); end
    load(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2);
    step();
    drive_nop();
    m_bubble = 1'b1;
    step();
    m_bubble = 1'b0;
    checks++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_valE !== 64'd0) begin errors++; $display("FAIL mbubble_M got=%h/%h/%h exp=1/F/0", M_icode, M_dstE, M_valE); end
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL mbubble_cc got=%b exp=000", cc); end
    load(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2);
    step();
    e_bubble = 1'b1; m_bubble = 1'b1;
    step();
    e_bubble = 1'b0; m_bubble = 1'b0;
    checks++; if (M_icode !== 4'h1 || e_valE !== 64'd0 || cc !== 3'b000) begin errors++; $display("FAIL both_bubble got=%h/%h/%b exp=1/0/000", M_icode, e_valE, cc); end
  endtask

  task automatic test_reset_inflight();
    load(4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 4'h2);
    step();
    rst = 1'b1; e_stall = 1'b1;
    step();
    rst = 1'b0; e_stall = 1'b0;
    checks++; if (M_icode !== 4'h1 || M_valE !== 64'd0 || e_valE !== 64'd0) begin errors++; $display("FAIL rst_inflight got=%h/%h/%h exp=1/0/0", M_icode, M_valE, e_valE); end
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rst_inflight_cc got=%b exp=100", cc); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_opq_sub();
    test_overflow_cc();
    test_cmov_jxx();
    test_stack_mem();
    test_stall_bubble();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
